// File: rtl/dmem_byte_port_if.sv
// -----------------------------------------------------------------------------
// dmem_byte_port_if
//
// Bundles every signal between the load/store unit, the byte sequencer and the
// byte-wide data SRAM.
//
// Parameters:
//   MEM_AW           SRAM byte-address width (default 16)
//
// Request side (LSU -> port):
//   req_valid, req_we, req_size[1:0], req_addr[31:0],
//   store_data_byte[7:0], store_data_half[15:0], store_data_word[31:0]
// Request side (port -> LSU):
//   req_ready
// Response side (port -> LSU):
//   resp_valid, resp_err, r_data_byte[7:0], r_data_half[15:0], r_data_word[31:0]
// SRAM side (port -> SRAM):
//   mem_addr[MEM_AW-1:0], mem_en, mem_we, mem_wdata[7:0]
// SRAM side (SRAM -> port):
//   mem_rdata[7:0]
//
// Modports:
//   slave   the sequencer's view (dmem_byte_port)
//   master  the environment's view (LSU plus SRAM)
// -----------------------------------------------------------------------------
interface dmem_byte_port_if #(
   parameter int MEM_AW = 16
) ();

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic [31:0]       req_addr;
   logic [7:0]        store_data_byte;
   logic [15:0]       store_data_half;
   logic [31:0]       store_data_word;

   logic              resp_valid;
   logic              resp_err;
   logic [7:0]        r_data_byte;
   logic [15:0]       r_data_half;
   logic [31:0]       r_data_word;

   logic [MEM_AW-1:0] mem_addr;
   logic              mem_en;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_addr,
             store_data_byte, store_data_half, store_data_word,
             mem_rdata,
      output req_ready, resp_valid, resp_err,
             r_data_byte, r_data_half, r_data_word,
             mem_addr, mem_en, mem_we, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_size, req_addr,
             store_data_byte, store_data_half, store_data_word,
             mem_rdata,
      input  req_ready, resp_valid, resp_err,
             r_data_byte, r_data_half, r_data_word,
             mem_addr, mem_en, mem_we, mem_wdata
   );

endinterface

// File: rtl/dmem_byte_port.sv
// -----------------------------------------------------------------------------
// dmem_byte_port
//
// Sequencer between the load/store unit and a byte-wide synchronous SRAM.
// Accepts one load or store at a time and splits it into 1, 2 or 4 single-byte
// beats at consecutive (wrapping) SRAM addresses, most significant byte first.
// Load bytes are shifted into a 32-bit register in memory order, so the byte
// at req_addr ends up in the top byte of the selected result width.
//
// Ports:
//   clk   sole clock, rising edge
//   rst   asynchronous, active-high reset; aborts any transaction in flight
//   bus   dmem_byte_port_if.slave (request, response and SRAM signals)
//
// Optional feature (compile-time macro):
//   DMEM_MISALIGN_CHECK_EN  when defined, misaligned half/word requests are
//                           rejected with resp_valid+resp_err one cycle after
//                           accept and never touch the SRAM. When undefined,
//                           resp_err is tied low and misaligned requests run
//                           as ordinary byte beats at the raw addresses.
// -----------------------------------------------------------------------------
module dmem_byte_port #(
   parameter int MEM_AW = 16
) (
   input  logic            clk,
   input  logic            rst,
   dmem_byte_port_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BEAT  = 2'd1,
      S_DRAIN = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   state_e            state_q,     state_d;
   logic [1:0]        beat_q,      beat_d;      // current beat index k
   logic [1:0]        last_q,      last_d;      // index of the final beat (N-1)
   logic              we_q,        we_d;
   logic [31:0]       sdata_q,     sdata_d;     // remaining store bytes, left-aligned
   logic [31:0]       rdata_q,     rdata_d;     // load assembly register
   logic              capture_q,   capture_d;   // mem_rdata holds a load byte this cycle
   logic              mem_en_q,    mem_en_d;
   logic              mem_we_q,    mem_we_d;
   logic [MEM_AW-1:0] mem_addr_q,  mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;

   logic [1:0]        req_last;
   logic [31:0]       req_sdata;
   logic              misalign;

   // Address bits above the SRAM width are intentionally discarded.
   logic              unused_addr_hi;
   assign unused_addr_hi = ^bus.req_addr[31:MEM_AW];

`ifdef DMEM_MISALIGN_CHECK_EN
   logic err_q, err_d;
   assign misalign = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                     (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   // Beat count minus one and store data left-aligned so that beat k always
   // takes bits [31:24] of a register shifted left by 8 per beat.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      req_last  = 2'd3;
      req_sdata = bus.store_data_word;
      case (bus.req_size)
         2'd0: begin
            req_last  = 2'd0;
            req_sdata = {bus.store_data_byte, 24'h000000};
         end
         2'd1: begin
            req_last  = 2'd1;
            req_sdata = {bus.store_data_half, 16'h0000};
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      last_d      = last_q;
      we_d        = we_q;
      sdata_d     = sdata_q;
      rdata_d     = rdata_q;
      capture_d   = mem_en_q & ~mem_we_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = 8'h00;
`ifdef DMEM_MISALIGN_CHECK_EN
      err_d       = err_q;
`endif

      // A load byte requested last cycle is on mem_rdata now.
      if (capture_q) begin
         rdata_d = {rdata_q[23:0], bus.mem_rdata};
      end

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               we_d   = bus.req_we;
               last_d = req_last;
               beat_d = 2'd0;
`ifdef DMEM_MISALIGN_CHECK_EN
               err_d  = misalign;
`endif
               if (misalign) begin
                  state_d = S_RESP;
               end else begin
                  state_d     = S_BEAT;
                  mem_en_d    = 1'b1;
                  mem_we_d    = bus.req_we;
                  mem_addr_d  = bus.req_addr[MEM_AW-1:0];
                  mem_wdata_d = bus.req_we ? req_sdata[31:24] : 8'h00;
                  sdata_d     = {req_sdata[23:0], 8'h00};
                  if (!bus.req_we) begin
                     rdata_d = 32'h0;
                  end
               end
            end
         end
         S_BEAT: begin
            if (beat_q == last_q) begin
               state_d = we_q ? S_RESP : S_DRAIN;
            end else begin
               // Memory outputs are registered, so the next beat is set up
               // one cycle ahead; the address wraps at the top of the SRAM.
               beat_d      = beat_q + 2'd1;
               mem_en_d    = 1'b1;
               mem_we_d    = we_q;
               mem_addr_d  = mem_addr_q + MEM_AW'(1);
               mem_wdata_d = we_q ? sdata_q[31:24] : 8'h00;
               sdata_d     = {sdata_q[23:0], 8'h00};
            end
         end
         S_DRAIN: state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         beat_q      <= 2'd0;
         last_q      <= 2'd0;
         we_q        <= 1'b0;
         sdata_q     <= 32'h0;
         rdata_q     <= 32'h0;
         capture_q   <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 8'h00;
`ifdef DMEM_MISALIGN_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         last_q      <= last_d;
         we_q        <= we_d;
         sdata_q     <= sdata_d;
         rdata_q     <= rdata_d;
         capture_q   <= capture_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
`ifdef DMEM_MISALIGN_CHECK_EN
         err_q       <= err_d;
`endif
      end
   end

   assign bus.req_ready   = (state_q == S_IDLE);
   assign bus.resp_valid  = (state_q == S_RESP);
`ifdef DMEM_MISALIGN_CHECK_EN
   assign bus.resp_err    = (state_q == S_RESP) & err_q;
`else
   assign bus.resp_err    = 1'b0;
`endif
   assign bus.r_data_word = rdata_q;
   assign bus.r_data_half = rdata_q[15:0];
   assign bus.r_data_byte = rdata_q[7:0];
   assign bus.mem_en      = mem_en_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_dmem_byte_port.sv
// -----------------------------------------------------------------------------
// tb_dmem_byte_port
//
// Directed bench for dmem_byte_port with a behavioural byte SRAM. Inputs are
// driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_dmem_byte_port;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   logic [31:0] last_r;   // r_data value the port should currently hold

   dmem_byte_port_if #(.MEM_AW(16)) bus_if ();

   dmem_byte_port #(.MEM_AW(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte-wide synchronous SRAM: read data appears the cycle after the strobe.
   logic [7:0] mem [0:65535];
   always @(posedge clk) begin
      if (bus_if.mem_en) begin
         if (bus_if.mem_we) mem[bus_if.mem_addr] <= bus_if.mem_wdata;
         else               bus_if.mem_rdata     <= mem[bus_if.mem_addr];
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one request, checks every beat, the drain cycle (loads), the
   // response cycle and the return to idle. exp_r is the r_data value that
   // must be visible at the response.
   task automatic run_op(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [15:0] hd, input logic [7:0] bd,
                         input logic [31:0] exp_r);
      int          n;
      logic [31:0] sd;
      logic [15:0] a;
      n  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      sd = (size == 2'd0) ? {bd, 24'h0} : (size == 2'd1) ? {hd, 16'h0} : wd;
      a  = addr[15:0];
      check("ready_idle", {31'b0, bus_if.req_ready}, 32'd1);
      bus_if.req_we          = we;
      bus_if.req_size        = size;
      bus_if.req_addr        = addr;
      bus_if.store_data_word = wd;
      bus_if.store_data_half = hd;
      bus_if.store_data_byte = bd;
      bus_if.req_valid       = 1'b1;
      step();
      bus_if.req_valid       = 1'b0;
      for (int k = 0; k < n; k++) begin
         check("beat_en",    {31'b0, bus_if.mem_en},    32'd1);
         check("beat_we",    {31'b0, bus_if.mem_we},    {31'b0, we});
         check("beat_addr",  {16'b0, bus_if.mem_addr},  {16'b0, a});
         check("beat_wdata", {24'b0, bus_if.mem_wdata}, we ? {24'b0, sd[31:24]} : 32'd0);
         check("beat_ready", {31'b0, bus_if.req_ready}, 32'd0);
         check("beat_resp",  {31'b0, bus_if.resp_valid}, 32'd0);
         sd = {sd[23:0], 8'h00};
         a  = a + 16'd1;
         step();
      end
      if (!we) begin
         check("drain_en",   {31'b0, bus_if.mem_en},     32'd0);
         check("drain_resp", {31'b0, bus_if.resp_valid}, 32'd0);
         step();
      end
      check("resp_valid",  {31'b0, bus_if.resp_valid}, 32'd1);
      check("resp_err",    {31'b0, bus_if.resp_err},   32'd0);
      check("resp_en",     {31'b0, bus_if.mem_en},     32'd0);
      check("r_data_word", bus_if.r_data_word,         exp_r);
      check("r_data_half", {16'b0, bus_if.r_data_half}, {16'b0, exp_r[15:0]});
      check("r_data_byte", {24'b0, bus_if.r_data_byte}, {24'b0, exp_r[7:0]});
      step();
      check("resp_done",   {31'b0, bus_if.resp_valid}, 32'd0);
      check("ready_back",  {31'b0, bus_if.req_ready},  32'd1);
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      last_r = 32'h0;
      rst    = 1'b1;
      bus_if.req_valid       = 1'b0;
      bus_if.req_we          = 1'b0;
      bus_if.req_size        = 2'd0;
      bus_if.req_addr        = 32'h0;
      bus_if.store_data_byte = 8'h0;
      bus_if.store_data_half = 16'h0;
      bus_if.store_data_word = 32'h0;

      // Reset state, sampled while reset is still asserted.
      #1;
      check("rst_ready",  {31'b0, bus_if.req_ready},  32'd1);
      check("rst_en",     {31'b0, bus_if.mem_en},     32'd0);
      check("rst_we",     {31'b0, bus_if.mem_we},     32'd0);
      check("rst_addr",   {16'b0, bus_if.mem_addr},   32'd0);
      check("rst_wdata",  {24'b0, bus_if.mem_wdata},  32'd0);
      check("rst_resp",   {31'b0, bus_if.resp_valid}, 32'd0);
      check("rst_err",    {31'b0, bus_if.resp_err},   32'd0);
      check("rst_rdata",  bus_if.r_data_word,         32'd0);
      step();
      step();
      rst = 1'b0;
      step();

      // Word store, top byte first to 0x100..0x103; the half/byte inputs carry
      // decoys so a wrong source selection shows up.
      run_op(1'b1, 2'd2, 32'h0000_0100, 32'h1122_3344, 16'hAAAA, 8'h55, last_r);
      check("mem_100", {24'b0, mem[16'h0100]}, 32'h11);
      check("mem_101", {24'b0, mem[16'h0101]}, 32'h22);
      check("mem_102", {24'b0, mem[16'h0102]}, 32'h33);
      check("mem_103", {24'b0, mem[16'h0103]}, 32'h44);

      // Word load of the same location.
      last_r = 32'h1122_3344;
      run_op(1'b0, 2'd2, 32'h0000_0100, 32'hFFFF_FFFF, 16'hFFFF, 8'hFF, last_r);

      // Upper request address bits are dropped: 0xABCD0100 maps to 0x0100.
      run_op(1'b0, 2'd3, 32'hABCD_0100, 32'h0, 16'h0, 8'h0, last_r);

      // Seed the top and bottom of the SRAM, then a half load that wraps.
      run_op(1'b1, 2'd0, 32'h0000_FFFF, 32'h0, 16'h0, 8'hBE, last_r);
      run_op(1'b1, 2'd0, 32'h0000_0000, 32'h0, 16'h0, 8'hEF, last_r);
      last_r = 32'h0000_BEEF;
      run_op(1'b0, 2'd1, 32'h0000_FFFF, 32'h0, 16'h0, 8'h0, last_r);

      // Byte store (r_data must not change), then byte load.
      run_op(1'b1, 2'd0, 32'h0000_0020, 32'h7777_7777, 16'h6666, 8'hA5, last_r);
      last_r = 32'h0000_00A5;
      run_op(1'b0, 2'd0, 32'h0000_0020, 32'h0, 16'h0, 8'h0, last_r);

      // Half store 0x5A3C to 0x21..0x22 with req_valid held through RESP:
      // no accept may happen until the port is back in IDLE.
      bus_if.req_we          = 1'b1;
      bus_if.req_size        = 2'd1;
      bus_if.req_addr        = 32'h0000_0021;
      bus_if.store_data_half = 16'h5A3C;
      bus_if.req_valid       = 1'b1;
      step();
      check("hold_b0_ready", {31'b0, bus_if.req_ready}, 32'd0);
      check("hold_b0_wdata", {24'b0, bus_if.mem_wdata}, 32'h5A);
      step();
      check("hold_b1_wdata", {24'b0, bus_if.mem_wdata}, 32'h3C);
      step();
      check("hold_resp",       {31'b0, bus_if.resp_valid}, 32'd1);
      check("hold_resp_ready", {31'b0, bus_if.req_ready},  32'd0);
      step();
      check("hold_no_reaccept", {31'b0, bus_if.mem_en},    32'd0);
      check("hold_idle_ready",  {31'b0, bus_if.req_ready}, 32'd1);
      bus_if.req_valid = 1'b0;
      step();
      check("hold_mem_21", {24'b0, mem[16'h0021]}, 32'h5A);
      check("hold_mem_22", {24'b0, mem[16'h0022]}, 32'h3C);

`ifdef DMEM_MISALIGN_CHECK_EN
      // Misaligned word load is rejected at T+1 without touching the SRAM.
      bus_if.req_we    = 1'b0;
      bus_if.req_size  = 2'd2;
      bus_if.req_addr  = 32'h0000_0102;
      bus_if.req_valid = 1'b1;
      step();
      bus_if.req_valid = 1'b0;
      check("mis_resp",  {31'b0, bus_if.resp_valid}, 32'd1);
      check("mis_err",   {31'b0, bus_if.resp_err},   32'd1);
      check("mis_en",    {31'b0, bus_if.mem_en},     32'd0);
      check("mis_we",    {31'b0, bus_if.mem_we},     32'd0);
      check("mis_rdata", bus_if.r_data_word,         last_r);
      step();
      check("mis_done",  {31'b0, bus_if.resp_valid}, 32'd0);
      check("mis_ready", {31'b0, bus_if.req_ready},  32'd1);
      check("mis_en2",   {31'b0, bus_if.mem_en},     32'd0);
`else
      // Without the check, a misaligned half load runs as ordinary beats.
      last_r = 32'h0000_2233;
      run_op(1'b0, 2'd1, 32'h0000_0101, 32'h0, 16'h0, 8'h0, last_r);
`endif

      // Clear 0x200..0x203, then reset during the second beat of a word store.
      run_op(1'b1, 2'd2, 32'h0000_0200, 32'h0, 16'h0, 8'h0, last_r);
      bus_if.req_we          = 1'b1;
      bus_if.req_size        = 2'd2;
      bus_if.req_addr        = 32'h0000_0200;
      bus_if.store_data_word = 32'hDEAD_BEEF;
      bus_if.req_valid       = 1'b1;
      step();
      bus_if.req_valid = 1'b0;
      check("rstmid_b0_addr", {16'b0, bus_if.mem_addr}, 32'h200);
      step();
      rst = 1'b1;
      #1;
      check("rstmid_we",    {31'b0, bus_if.mem_we},     32'd0);
      check("rstmid_en",    {31'b0, bus_if.mem_en},     32'd0);
      check("rstmid_ready", {31'b0, bus_if.req_ready},  32'd1);
      check("rstmid_rdata", bus_if.r_data_word,         32'd0);
      step();
      step();
      rst = 1'b0;
      begin
         int activity;
         activity = 0;
         for (int c = 0; c < 6; c++) begin
            if (bus_if.resp_valid || bus_if.mem_en) activity++;
            step();
         end
         check("rstmid_quiet", activity, 32'd0);
      end
      check("rstmid_mem_200", {24'b0, mem[16'h0200]}, 32'hDE);
      check("rstmid_mem_201", {24'b0, mem[16'h0201]}, 32'h00);
      check("rstmid_mem_202", {24'b0, mem[16'h0202]}, 32'h00);

      // Port works normally after the abort.
      last_r = 32'hDE00_0000;
      run_op(1'b0, 2'd2, 32'h0000_0200, 32'h0, 16'h0, 8'h0, last_r);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_byte_port.md
# dmem_byte_port

Sequencer between the load/store unit and a byte-wide synchronous data SRAM. It accepts one load or store request at a time, splits it into 1, 2 or 4 single-byte beats at consecutive addresses, and returns the load bytes in memory order. The load unit byte-swaps and sign-extends that data. The pipeline stalls on `req_ready` and resumes on `resp_valid`.

## Interface
- `MEM_AW`, default 16: SRAM byte-address width.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when high together with `req_valid`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word; 3 = word.
- `req_addr` in 32: byte address of the first beat.
- `store_data_byte` in 8: byte store data.
- `store_data_half` in 16: half store data, bits [15:8] go to `req_addr`.
- `store_data_word` in 32: word store data, bits [31:24] go to `req_addr`.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_err` out 1: rejected misaligned request; only meaningful with `resp_valid`.
- `r_data_byte` out 8: load result, byte.
- `r_data_half` out 16: load result, half.
- `r_data_word` out 32: load result, word.
- `mem_addr` out MEM_AW: SRAM address.
- `mem_en` out 1: SRAM access strobe.
- `mem_we` out 1: SRAM write strobe.
- `mem_wdata` out 8: SRAM write byte.
- `mem_rdata` in 8: SRAM read byte, valid the cycle after `mem_en` with `mem_we` = 0.

## Operation
- Beat count N: 1 for byte, 2 for half, 4 for size 2 or 3.
- State machine IDLE, BEAT, DRAIN, RESP.
  - IDLE to BEAT on accept.
  - BEAT lasts N cycles, with beat counter k = 0..N-1.
  - After the last beat: loads go to DRAIN, stores go to RESP.
  - DRAIN to RESP after one cycle.
  - RESP to IDLE after one cycle.
- `req_ready` = (state == IDLE). It reads 1 during reset. Request inputs are registered on accept and ignored afterwards.
- Beat k:
  - `mem_en` = 1 and `mem_addr` = (req_addr + k) mod 2^MEM_AW. Upper address bits are dropped, and the address wraps to 0 past the top.
  - Store: `mem_we` = 1 and `mem_wdata` = store data byte (top byte first), i.e. word bits [31-8k : 24-8k], half bits [15-8k : 8-8k], or the whole byte.
  - Load: `mem_we` = 0 and `mem_wdata` = 0.
- Load assembly: a 32-bit register is cleared on accept and shifts `{reg[23:0], mem_rdata}` in each cycle after a load beat.
  - `r_data_word` = reg, `r_data_half` = reg[15:0], `r_data_byte` = reg[7:0].
  - As a result, `r_data_word[31:24]` and `r_data_half[15:8]` hold the byte at `req_addr`.
- The r_data outputs hold their value until the next load is accepted. Stores do not alter them.
- `resp_valid` is high in RESP only. `resp_err` = 0 except in the Configuration case.

## Timing
- Accept at cycle T. Beats occupy cycles T+1..T+N.
- Store: `resp_valid` at T+N+1. Next accept no earlier than T+N+2.
- Load: last byte arrives on `mem_rdata` at T+N+1 and is captured at the end of that cycle. `resp_valid` and final r_data both appear at T+N+2.
- Byte load latency: 3 cycles. Word load latency: 6 cycles.
- `mem_*` outputs are registered, with no combinational path from request inputs.
- Reset values: state IDLE, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `resp_valid`, `resp_err` and all r_data = 0.
- Reset mid-operation: the transaction is aborted immediately, with no further beats and no `resp_valid`. Bytes already written stay written.
- `req_valid` held high through RESP is not accepted until IDLE. No back-to-back accept.

## Configuration
- Macro `DMEM_MISALIGN_CHECK_EN`.
- Defined: a half request with `req_addr[0]` = 1, or a word request with `req_addr[1:0]` ≠ 0, skips BEAT and DRAIN.
  - State goes IDLE to RESP, so `resp_valid` = 1 with `resp_err` = 1 at T+1.
  - `mem_en` and `mem_we` stay 0, and r_data is unchanged.
- Undefined: the alignment check is absent, `resp_err` is tied to 0, and misaligned requests run as N sequential byte beats at the raw addresses.

## Test plan
- Word store 0x11223344 to addr 0x100 → bytes 0x11, 0x22, 0x33, 0x44 written to 0x100..0x103 at T+1..T+4, `resp_valid` at T+5.
- Word load from 0x100 after that store → `resp_valid` at T+6, `r_data_word` = 0x11223344, `r_data_half` = 0x3344, `r_data_byte` = 0x44.
- Half load at 0xFFFF with MEM_AW = 16, macro undefined → `mem_addr` 0xFFFF then 0x0000, `r_data_half` = {mem[0xFFFF], mem[0x0000]}.
- Byte store 0xA5 to 0x20, then byte load from 0x20 → `r_data_byte` = 0xA5 at T+3, `r_data_word` = 0x000000A5.
- `rst` pulsed in cycle T+2 of a word store → `mem_we` low from the reset edge, only byte 0 written, no `resp_valid`, `req_ready` = 1.
- With the macro defined, word load at 0x102 → `resp_valid` = 1 and `resp_err` = 1 at T+1, no `mem_en`, r_data unchanged.
